load_store_unit: RTL and testbench

// Data-memory bus master for the core's load/store path; produces MemoryData for writeback.

---
 rtl/load_store_unit.sv | 164 ++++++++++++++++
 tb/tb_load_store_unit.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Data-memory bus master for the load/store path: one valid/ready request per
// access, an rvalid response for loads, and an extended LoadData word for writeback.
module load_store_unit #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [2:0]  Funct3,
   input  logic [31:0] Addr,
   input  logic [31:0] StoreData,
   output logic        Stall,
   output logic [31:0] LoadData,
   output logic        AccessErr,
   output logic        BusValid,
   input  logic        BusReady,
   output logic [31:0] BusAddr,
   output logic        BusWe,
   output logic [3:0]  BusWstrb,
   output logic [31:0] BusWdata,
   input  logic        BusRValid,
   input  logic [31:0] BusRData,
   output logic [1:0]  fsm_state
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] T_MAX  = CW'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2, S_DONE = 2'd3} state_t;

   state_t        state, state_next;
   logic [CW-1:0] cnt;
   logic          err_q;
   logic [2:0]    f3_q;
   logic [1:0]    lane_q;
   logic [31:0]   load_data;
   logic          op, illegal, timeout, finish_ok;
   logic [31:0]   shifted, extracted;
   logic [15:0]   half_sel;

   assign op = MemRead || MemWrite;

   // Legality is judged only from the datapath inputs present in IDLE.
   always_comb begin
      illegal = 1'b0;
      if (MemRead && MemWrite)
         illegal = 1'b1;
      else if (MemRead)
         illegal = (Funct3 == 3'b011) || (Funct3[2:1] == 2'b11);
      else
         illegal = Funct3[2] || (Funct3[1:0] == 2'b11);
      if ((Funct3[1:0] == 2'b01) && Addr[0])
         illegal = 1'b1;
      if ((Funct3[1:0] == 2'b10) && (Addr[1:0] != 2'b00))
         illegal = 1'b1;
   end

   assign timeout   = (cnt >= T_LAST);
   assign finish_ok = ((state == S_REQ) && BusReady) || ((state == S_WAIT) && BusRValid);

   always_comb begin
      shifted   = BusRData >> {lane_q, 3'b000};
      half_sel  = lane_q[1] ? BusRData[31:16] : BusRData[15:0];
      extracted = BusRData;
      case (f3_q)
         3'b000:  extracted = {{24{shifted[7]}}, shifted[7:0]};
         3'b100:  extracted = {24'd0, shifted[7:0]};
         3'b001:  extracted = {{16{half_sel[15]}}, half_sel};
         3'b101:  extracted = {16'd0, half_sel};
         default: extracted = BusRData;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         state <= S_IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE: if (op) state_next = illegal ? S_DONE : S_REQ;
         S_REQ: begin
            if (BusReady)     state_next = BusWe ? S_DONE : S_WAIT;
            else if (timeout) state_next = S_DONE;
         end
         S_WAIT: if (BusRValid || timeout) state_next = S_DONE;
         default: state_next = S_IDLE;
      endcase
   end

   always_comb begin
      BusValid  = (state == S_REQ);
      Stall     = reset_n && (((state == S_IDLE) && op) || (state == S_REQ) || (state == S_WAIT));
      AccessErr = (state == S_DONE) && err_q;
      LoadData  = load_data;
      fsm_state = state;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         BusAddr   <= '0;
         BusWe     <= 1'b0;
         BusWstrb  <= '0;
         BusWdata  <= '0;
         load_data <= '0;
         err_q     <= 1'b0;
         f3_q      <= '0;
         lane_q    <= '0;
         cnt       <= '0;
      end else begin
         case (state)
            S_IDLE: if (op) begin
               if (illegal) begin
                  err_q     <= 1'b1;
                  load_data <= '0;
               end else begin
                  err_q   <= 1'b0;
                  cnt     <= '0;
                  f3_q    <= Funct3;
                  lane_q  <= Addr[1:0];
                  BusAddr <= {Addr[31:2], 2'b00};
                  BusWe   <= MemWrite;
                  if (MemWrite) begin
                     case (Funct3[1:0])
                        2'b00: begin
                           BusWdata <= {4{StoreData[7:0]}};
                           BusWstrb <= 4'b0001 << Addr[1:0];
                        end
                        2'b01: begin
                           BusWdata <= {2{StoreData[15:0]}};
                           BusWstrb <= Addr[1] ? 4'b1100 : 4'b0011;
                        end
                        default: begin
                           BusWdata <= StoreData;
                           BusWstrb <= 4'b1111;
                        end
                     endcase
                  end else begin
                     BusWdata <= '0;
                     BusWstrb <= 4'b0000;
                  end
               end
            end
            S_REQ, S_WAIT: begin
               if (cnt != T_MAX)
                  cnt <= cnt + CW'(1);
               if ((state == S_WAIT) && BusRValid)
                  load_data <= extracted;
               else if (!finish_ok && timeout) begin
                  err_q     <= 1'b1;
                  load_data <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed load/store/error/timeout
// scenarios plus randomised back-to-back traffic against a scoreboard queue.
module tb_load_store_unit;

   logic        clk, reset_n;
   logic        MemRead, MemWrite;
   logic [2:0]  Funct3;
   logic [31:0] Addr, StoreData;
   logic        Stall, AccessErr, BusValid, BusReady, BusWe, BusRValid;
   logic [31:0] LoadData, BusAddr, BusWdata, BusRData;
   logic [3:0]  BusWstrb;
   logic [1:0]  fsm_state;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] exp_q[$];

   load_store_unit #(.TIMEOUT_CYCLES(255)) dut (
      .clk(clk), .reset_n(reset_n), .MemRead(MemRead), .MemWrite(MemWrite),
      .Funct3(Funct3), .Addr(Addr), .StoreData(StoreData), .Stall(Stall),
      .LoadData(LoadData), .AccessErr(AccessErr), .BusValid(BusValid),
      .BusReady(BusReady), .BusAddr(BusAddr), .BusWe(BusWe), .BusWstrb(BusWstrb),
      .BusWdata(BusWdata), .BusRValid(BusRValid), .BusRData(BusRData),
      .fsm_state(fsm_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drives one access and acts as the bus slave; returns what it observed.
   task automatic run_op(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [31:0] rdata, input int ready_lat, input int rv_lat,
                         output int stall_cnt, output int valid_cnt, output int err_cnt,
                         output logic [31:0] o_addr, output logic o_we,
                         output logic [3:0] o_strb, output logic [31:0] o_wdata,
                         output logic [31:0] o_load, output logic stable, output logic done);
      int   wait_cnt;
      logic accepted;
      stall_cnt = 0; valid_cnt = 0; err_cnt = 0; wait_cnt = 0;
      accepted = 1'b0; stable = 1'b1; done = 1'b0;
      o_addr = '0; o_we = 1'b0; o_strb = '0; o_wdata = '0; o_load = '0;
      @(negedge clk);
      MemRead = rd; MemWrite = wr; Funct3 = f3; Addr = addr; StoreData = sdata;
      BusRData = rdata;
      for (int cyc = 0; cyc < 600 && !done; cyc++) begin
         if (cyc > 0) @(negedge clk);
         if (cyc == 1) begin
            MemRead = 1'b0; MemWrite = 1'b0;
            Funct3 = 3'($urandom_range(7, 0)); Addr = $urandom; StoreData = $urandom;
         end
         BusReady  = BusValid && (valid_cnt >= ready_lat);
         BusRValid = accepted && (wait_cnt >= rv_lat);
         #1;
         if (Stall) stall_cnt++;
         if (AccessErr) err_cnt++;
         if (BusValid) begin
            if (valid_cnt == 0) begin
               o_addr = BusAddr; o_we = BusWe; o_strb = BusWstrb; o_wdata = BusWdata;
            end else if (BusAddr !== o_addr || BusWe !== o_we ||
                         BusWstrb !== o_strb || BusWdata !== o_wdata) begin
               stable = 1'b0;
            end
            valid_cnt++;
         end
         if (cyc > 0 && !Stall) begin
            done = 1'b1;
            o_load = LoadData;
         end else if (BusValid && BusReady) begin
            accepted = 1'b1;
         end else if (accepted) begin
            wait_cnt++;
         end
      end
      BusReady = 1'b0; BusRValid = 1'b0;
   endtask

   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] a,
                                              input logic [31:0] d);
      logic [7:0]  b;
      logic [15:0] h;
      case (a)
         2'd0: b = d[7:0];
         2'd1: b = d[15:8];
         2'd2: b = d[23:16];
         default: b = d[31:24];
      endcase
      h = (a >= 2'd2) ? d[31:16] : d[15:0];
      case (f3)
         3'b000: return {b[7] ? 24'hFFFFFF : 24'h0, b};
         3'b100: return {24'h0, b};
         3'b001: return {h[15] ? 16'hFFFF : 16'h0, h};
         3'b101: return {16'h0, h};
         default: return d;
      endcase
   endfunction

   task automatic test_reset();
      #1;
      n_checks++;
      if (BusValid !== 1'b0 || BusWe !== 1'b0 || BusWstrb !== 4'h0) begin
         n_fail++;
         $display("FAIL reset_bus_ctrl: valid=%b we=%b strb=%b required 0 0 0000", BusValid, BusWe, BusWstrb);
      end
      n_checks++;
      if (BusAddr !== 32'h0 || BusWdata !== 32'h0 || LoadData !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_data: addr=%h wdata=%h load=%h required all 0", BusAddr, BusWdata, LoadData);
      end
      n_checks++;
      if (Stall !== 1'b0 || AccessErr !== 1'b0 || fsm_state !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_status: stall=%b err=%b state=%0d required 0 0 0", Stall, AccessErr, fsm_state);
      end
   endtask

   task automatic test_load_word();
      int s, v, e; logic [31:0] a, wd, ld, exp; logic we, st, dn; logic [3:0] sb;
      exp_q.push_back(32'hDEADBEEF);
      run_op(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, s, v, e, a, we, sb, wd, ld, st, dn);
      exp = exp_q.pop_front();
      n_checks++;
      if (!dn || ld !== exp) begin
         n_fail++; $display("FAIL lw_data: got %h done=%b required %h", ld, dn, exp);
      end
      n_checks++;
      if (a !== 32'h100 || we !== 1'b0 || sb !== 4'h0) begin
         n_fail++; $display("FAIL lw_bus: addr=%h we=%b strb=%b required 100 0 0000", a, we, sb);
      end
      n_checks++;
      if (s !== 3 || e !== 0) begin
         n_fail++; $display("FAIL lw_stall: stall=%0d err=%0d required 3 0", s, e);
      end
   endtask

   task automatic test_load_extend();
      logic [2:0]  f3s[4]   = '{3'b000, 3'b100, 3'b101, 3'b001};
      logic [31:0] adrs[4]  = '{32'h103, 32'h103, 32'h102, 32'h102};
      logic [31:0] exps[4]  = '{32'hFFFFFF80, 32'h00000080, 32'h000080FF, 32'hFFFF80FF};
      int s, v, e; logic [31:0] a, wd, ld, exp; logic we, st, dn; logic [3:0] sb;
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(exps[i]);
         run_op(1'b1, 1'b0, f3s[i], adrs[i], 32'h0, 32'h80FF0000, 0, 0, s, v, e, a, we, sb, wd, ld, st, dn);
         exp = exp_q.pop_front();
         n_checks++;
         if (!dn || ld !== exp || a !== 32'h100) begin
            n_fail++;
            $display("FAIL load_ext_%0d: data=%h addr=%h required %h 00000100", i, ld, a, exp);
         end
      end
   endtask

   task automatic test_store();
      logic [2:0]  f3s[3]   = '{3'b000, 3'b001, 3'b010};
      logic [31:0] adrs[3]  = '{32'h201, 32'h202, 32'h204};
      logic [3:0]  strbs[3] = '{4'b0010, 4'b1100, 4'b1111};
      logic [31:0] wds[3]   = '{32'h78787878, 32'h56785678, 32'h12345678};
      int s, v, e; logic [31:0] a, wd, ld; logic we, st, dn; logic [3:0] sb;
      for (int i = 0; i < 3; i++) begin
         run_op(1'b0, 1'b1, f3s[i], adrs[i], 32'h12345678, 32'h0, 0, 0, s, v, e, a, we, sb, wd, ld, st, dn);
         n_checks++;
         if (sb !== strbs[i] || wd !== wds[i] || we !== 1'b1 || a !== {adrs[i][31:2], 2'b00}) begin
            n_fail++;
            $display("FAIL store_%0d: strb=%b wdata=%h we=%b addr=%h required %b %h 1 %h",
                     i, sb, wd, we, a, strbs[i], wds[i], {adrs[i][31:2], 2'b00});
         end
         n_checks++;
         if (s !== 2 || v !== 1 || e !== 0 || ld !== 32'hFFFF80FF) begin
            n_fail++;
            $display("FAIL store_%0d_timing: stall=%0d valid=%0d err=%0d load=%h required 2 1 0 ffff80ff",
                     i, s, v, e, ld);
         end
      end
   endtask

   task automatic test_illegal();
      logic        rds[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      logic        wrs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      logic [2:0]  f3s[5]  = '{3'b010, 3'b010, 3'b001, 3'b011, 3'b100};
      logic [31:0] adrs[5] = '{32'h102, 32'h100, 32'h101, 32'h100, 32'h100};
      int s, v, e; logic [31:0] a, wd, ld, exp; logic we, st, dn; logic [3:0] sb;
      for (int i = 0; i < 5; i++) begin
         exp_q.push_back(32'h0);
         run_op(rds[i], wrs[i], f3s[i], adrs[i], 32'hA5A5A5A5, 32'hFFFFFFFF, 0, 0,
                s, v, e, a, we, sb, wd, ld, st, dn);
         exp = exp_q.pop_front();
         n_checks++;
         if (v !== 0 || e !== 1 || s !== 1 || ld !== exp) begin
            n_fail++;
            $display("FAIL illegal_%0d: valid_cycles=%0d err=%0d stall=%0d load=%h required 0 1 1 %h",
                     i, v, e, s, ld, exp);
         end
      end
   endtask

   task automatic test_timeout();
      int s, v, e; logic [31:0] a, wd, ld, exp; logic we, st, dn; logic [3:0] sb;
      exp_q.push_back(32'h0);
      run_op(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 32'h11111111, 10000, 0,
             s, v, e, a, we, sb, wd, ld, st, dn);
      exp = exp_q.pop_front();
      n_checks++;
      if (!dn || v !== 255 || !st || a !== 32'h300) begin
         n_fail++;
         $display("FAIL timeout_bus: done=%b valid_cycles=%0d stable=%b addr=%h required 1 255 1 300", dn, v, st, a);
      end
      n_checks++;
      if (e !== 1 || s !== 256 || ld !== exp) begin
         n_fail++;
         $display("FAIL timeout_err: err=%0d stall=%0d load=%h required 1 256 %h", e, s, ld, exp);
      end
      @(negedge clk); #1;
      n_checks++;
      if (fsm_state !== 2'd0 || AccessErr !== 1'b0) begin
         n_fail++; $display("FAIL timeout_idle: state=%0d err=%b required 0 0", fsm_state, AccessErr);
      end
   endtask

   task automatic test_back_to_back();
      logic [2:0] ld_f3[5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      int s, v, e, rl, vl, exp_s; logic [31:0] a, wd, ld, exp, adr, sd, rdat, exp_wd;
      logic we, st, dn, is_ld; logic [3:0] sb, exp_sb; logic [2:0] f3;
      for (int i = 0; i < 24; i++) begin
         is_ld = 1'($urandom_range(1, 0));
         f3 = is_ld ? ld_f3[$urandom_range(4, 0)] : 3'($urandom_range(2, 0));
         adr = $urandom;
         if (f3[1:0] == 2'b01) adr[0] = 1'b0;
         if (f3[1:0] == 2'b10) adr[1:0] = 2'b00;
         sd = $urandom; rdat = $urandom;
         rl = $urandom_range(3, 0); vl = $urandom_range(3, 0);
         exp_s = 2 + rl + (is_ld ? vl + 1 : 0);
         if (is_ld) exp_q.push_back(model_load(f3, adr[1:0], rdat));
         run_op(is_ld, !is_ld, f3, adr, sd, rdat, rl, vl, s, v, e, a, we, sb, wd, ld, st, dn);
         n_checks++;
         if (!dn || s !== exp_s || e !== 0 || !st || a !== {adr[31:2], 2'b00} || we !== !is_ld) begin
            n_fail++;
            $display("FAIL b2b_%0d_timing: done=%b stall=%0d err=%0d stable=%b addr=%h we=%b required 1 %0d 0 1 %h %b",
                     i, dn, s, e, st, a, we, exp_s, {adr[31:2], 2'b00}, !is_ld);
         end
         if (is_ld) begin
            exp = exp_q.pop_front();
            n_checks++;
            if (ld !== exp || sb !== 4'h0) begin
               n_fail++;
               $display("FAIL b2b_%0d_load: f3=%b data=%h strb=%b required %h 0000", i, f3, ld, sb, exp);
            end
         end else begin
            case (f3)
               3'b000: begin exp_sb = 4'b0001 << adr[1:0]; exp_wd = {4{sd[7:0]}}; end
               3'b001: begin exp_sb = 4'b0011 << adr[1:0]; exp_wd = {2{sd[15:0]}}; end
               default: begin exp_sb = 4'b1111; exp_wd = sd; end
            endcase
            n_checks++;
            if (sb !== exp_sb || wd !== exp_wd) begin
               n_fail++;
               $display("FAIL b2b_%0d_store: f3=%b strb=%b wdata=%h required %b %h", i, f3, sb, wd, exp_sb, exp_wd);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      int s, v, e; logic [31:0] a, wd, ld, exp; logic we, st, dn; logic [3:0] sb;
      exp_q.push_back(32'h55AA1234);
      run_op(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 32'h55AA1234, 0, 0, s, v, e, a, we, sb, wd, ld, st, dn);
      exp = exp_q.pop_front();
      n_checks++;
      if (ld !== exp) begin
         n_fail++; $display("FAIL pre_reset_load: got %h required %h", ld, exp);
      end
      @(negedge clk);
      MemRead = 1'b1; Funct3 = 3'b010; Addr = 32'h80;
      @(negedge clk);
      MemRead = 1'b0; BusReady = 1'b1;
      @(negedge clk);
      BusReady = 1'b0; #1;
      n_checks++;
      if (fsm_state !== 2'd2 || Stall !== 1'b1) begin
         n_fail++; $display("FAIL mid_wait: state=%0d stall=%b required 2 1", fsm_state, Stall);
      end
      #1 reset_n = 1'b0;
      #1;
      n_checks++;
      if (BusValid !== 1'b0 || Stall !== 1'b0 || LoadData !== 32'h0 || BusAddr !== 32'h0 ||
          AccessErr !== 1'b0 || fsm_state !== 2'd0) begin
         n_fail++;
         $display("FAIL mid_reset: valid=%b stall=%b load=%h addr=%h err=%b state=%0d required all 0",
                  BusValid, Stall, LoadData, BusAddr, AccessErr, fsm_state);
      end
      BusRData = 32'hCAFEF00D; BusRValid = 1'b1;
      @(negedge clk);
      BusRValid = 1'b0; reset_n = 1'b1; #1;
      n_checks++;
      if (LoadData !== 32'h0 || fsm_state !== 2'd0) begin
         n_fail++; $display("FAIL post_reset_idle: load=%h state=%0d required 0 0", LoadData, fsm_state);
      end
      exp_q.push_back(32'h0BADCAFE);
      run_op(1'b1, 1'b0, 3'b010, 32'h104, 32'h0, 32'h0BADCAFE, 0, 0, s, v, e, a, we, sb, wd, ld, st, dn);
      exp = exp_q.pop_front();
      n_checks++;
      if (!dn || ld !== exp || s !== 3 || a !== 32'h104) begin
         n_fail++;
         $display("FAIL post_reset_lw: data=%h stall=%0d addr=%h required %h 3 104", ld, s, a, exp);
      end
   endtask

   initial begin
      reset_n = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; Funct3 = 3'b000;
      Addr = '0; StoreData = '0; BusReady = 1'b0; BusRValid = 1'b0; BusRData = '0;
      repeat (3) @(posedge clk);
      test_reset();
      @(negedge clk);
      reset_n = 1'b1;
      test_load_word();
      test_load_extend();
      test_store();
      test_illegal();
      test_timeout();
      test_back_to_back();
      test_reset_mid();
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++; $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
